// File: rtl/sdrc_bs_upconv.sv
// sdrc_bs_upconv: adapts a 16-bit or 8-bit application beat stream to a
// 32-bit SDRAM controller port. Requests are split into sub-requests of
// at most CHUNK words, each staged through one shared word buffer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an app request
// W_FILL  | collecting app write beats into the buffer
// W_REQ   | write sub-request presented to the controller
// W_DRAIN | handing buffered words to the controller
// R_REQ   | read sub-request presented to the controller
// R_FILL  | storing returned read words into the buffer
// R_DRAIN | replaying buffered words as app read beats

module sdrc_bs_upconv #(
    parameter int APP_AW = 30,
    parameter int APP_RW = 9,
    parameter int CHUNK  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        app_width,
    input  logic              app_sdr_req,
    input  logic [APP_AW-1:0] app_req_addr,
    input  logic [APP_RW-1:0] app_req_len,
    input  logic              app_req_wr_n,
    output logic              app_req_ack,
    input  logic [15:0]       app_wr_data,
    input  logic [1:0]        app_wr_en_n,
    output logic              app_wr_next,
    output logic [15:0]       app_rd_data,
    output logic              app_rd_valid,
    output logic              app_sdr_req_int,
    output logic [APP_AW-1:0] app_req_addr_int,
    output logic [APP_RW-1:0] app_req_len_int,
    output logic              app_req_wr_n_int,
    input  logic              app_req_ack_int,
    output logic [31:0]       app_wr_data_int,
    output logic [3:0]        app_wr_en_n_int,
    input  logic              app_wr_next_int,
    input  logic [31:0]       app_rd_data_int,
    input  logic              app_rd_valid_int
);
    localparam int CW = $clog2(CHUNK);
    localparam int NW = CW + 1;

    typedef enum logic [2:0] {
        IDLE, W_FILL, W_REQ, W_DRAIN, R_REQ, R_FILL, R_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic              mode8_q, mode8_d;
    logic              wr_n_q, wr_n_d;
    logic [APP_AW-1:0] addr_q, addr_d;
    logic [APP_RW-1:0] rem_q, rem_d;
    logic [NW-1:0]     n_q, n_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [1:0]        lane_q, lane_d;

    logic [31:0]       buf_data_q [CHUNK];
    logic [3:0]        buf_en_q   [CHUNK];
    logic              buf_we;
    logic [31:0]       buf_wdata;
    logic [3:0]        buf_wen;

    logic [31:0]       cur_data;
    logic [3:0]        cur_en;
    logic [31:0]       fill_data;
    logic [3:0]        fill_en;
    logic [15:0]       rd_beat;
    logic              last_word;
    logic              last_lane;
    logic              acc_mode8;
    logic [APP_AW-1:0] acc_addr;
    logic [APP_RW-1:0] acc_words;

    // Words in the next sub-request: min(remaining, CHUNK).
    function automatic logic [NW-1:0] chunk_of(input logic [APP_RW-1:0] r);
        if (r >= APP_RW'(CHUNK)) chunk_of = NW'(CHUNK);
        else                     chunk_of = r[NW-1:0];
    endfunction

    assign cur_data  = buf_data_q[ptr_q];
    assign cur_en    = buf_en_q[ptr_q];
    assign last_word = ({1'b0, ptr_q} == (n_q - NW'(1)));
    assign last_lane = mode8_q ? (lane_q == 2'd3) : (lane_q == 2'd1);

    // 00 is treated like 01; only 1x selects byte beats.
    assign acc_mode8 = (app_width inside {2'b10, 2'b11});
    assign acc_addr  = acc_mode8 ? (app_req_addr >> 2) : (app_req_addr >> 1);
    assign acc_words = acc_mode8 ? (app_req_len >> 2)  : (app_req_len >> 1);

    assign app_req_addr_int = addr_q;
    assign app_req_len_int  = APP_RW'(n_q);
    assign app_req_wr_n_int = wr_n_q;
    assign app_wr_data_int  = cur_data;
    assign app_wr_en_n_int  = cur_en;
    assign app_rd_data      = (state_q == R_DRAIN) ? rd_beat : 16'h0000;

    // Merge the incoming app beat into its little-endian lane of the current word.
    always_comb begin
        fill_data = cur_data;
        fill_en   = cur_en;
        if (mode8_q) begin
            case (lane_q)
                2'd0: begin fill_data[7:0]   = app_wr_data[7:0]; fill_en[0] = app_wr_en_n[0]; end
                2'd1: begin fill_data[15:8]  = app_wr_data[7:0]; fill_en[1] = app_wr_en_n[0]; end
                2'd2: begin fill_data[23:16] = app_wr_data[7:0]; fill_en[2] = app_wr_en_n[0]; end
                default: begin fill_data[31:24] = app_wr_data[7:0]; fill_en[3] = app_wr_en_n[0]; end
            endcase
        end else if (lane_q[0]) begin
            fill_data[31:16] = app_wr_data;
            fill_en[3:2]     = app_wr_en_n;
        end else begin
            fill_data[15:0] = app_wr_data;
            fill_en[1:0]    = app_wr_en_n;
        end
    end

    // Pick the read beat for the current lane, same order as packing.
    always_comb begin
        rd_beat = 16'h0000;
        if (mode8_q) begin
            case (lane_q)
                2'd0:    rd_beat = {8'h00, cur_data[7:0]};
                2'd1:    rd_beat = {8'h00, cur_data[15:8]};
                2'd2:    rd_beat = {8'h00, cur_data[23:16]};
                default: rd_beat = {8'h00, cur_data[31:24]};
            endcase
        end else begin
            rd_beat = lane_q[0] ? cur_data[31:16] : cur_data[15:0];
        end
    end

    // Next-state, counters and strobes.
    always_comb begin
        state_d         = state_q;
        mode8_d         = mode8_q;
        wr_n_d          = wr_n_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        n_d             = n_q;
        ptr_d           = ptr_q;
        lane_d          = lane_q;
        buf_we          = 1'b0;
        buf_wdata       = fill_data;
        buf_wen         = fill_en;
        app_req_ack     = 1'b0;
        app_wr_next     = 1'b0;
        app_rd_valid    = 1'b0;
        app_sdr_req_int = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by reset so no acknowledge leaks out while reset is held.
                if (app_sdr_req && !reset) begin
                    app_req_ack = 1'b1;
                    mode8_d     = acc_mode8;
                    wr_n_d      = app_req_wr_n;
                    addr_d      = acc_addr;
                    rem_d       = acc_words;
                    n_d         = chunk_of(acc_words);
                    ptr_d       = '0;
                    lane_d      = 2'd0;
                    if (acc_words != '0)
                        state_d = app_req_wr_n ? R_REQ : W_FILL;
                end
            end
            W_FILL: begin
                app_wr_next = 1'b1;
                buf_we      = 1'b1;
                if (last_lane) begin
                    lane_d = 2'd0;
                    if (last_word) begin
                        ptr_d   = '0;
                        state_d = W_REQ;
                    end else begin
                        ptr_d = ptr_q + CW'(1);
                    end
                end else begin
                    lane_d = lane_q + 2'd1;
                end
            end
            W_REQ, R_REQ: begin
                app_sdr_req_int = 1'b1;
                if (app_req_ack_int) begin
                    addr_d  = addr_q + APP_AW'(n_q);
                    rem_d   = rem_q - APP_RW'(n_q);
                    state_d = (state_q == W_REQ) ? W_DRAIN : R_FILL;
                end
            end
            W_DRAIN: begin
                if (app_wr_next_int) begin
                    if (last_word) begin
                        ptr_d = '0;
                        if (rem_q != '0) begin
                            n_d     = chunk_of(rem_q);
                            state_d = W_FILL;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        ptr_d = ptr_q + CW'(1);
                    end
                end
            end
            R_FILL: begin
                if (app_rd_valid_int) begin
                    buf_we    = 1'b1;
                    buf_wdata = app_rd_data_int;
                    buf_wen   = cur_en;
                    if (last_word) begin
                        ptr_d   = '0;
                        state_d = R_DRAIN;
                    end else begin
                        ptr_d = ptr_q + CW'(1);
                    end
                end
            end
            R_DRAIN: begin
                app_rd_valid = 1'b1;
                if (last_lane) begin
                    lane_d = 2'd0;
                    if (last_word) begin
                        ptr_d = '0;
                        if (rem_q != '0) begin
                            n_d     = chunk_of(rem_q);
                            state_d = R_REQ;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        ptr_d = ptr_q + CW'(1);
                    end
                end else begin
                    lane_d = lane_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode8_q <= 1'b0;
            wr_n_q  <= 1'b1;
            addr_q  <= '0;
            rem_q   <= '0;
            n_q     <= '0;
            ptr_q   <= '0;
            lane_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            mode8_q <= mode8_d;
            wr_n_q  <= wr_n_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            n_q     <= n_d;
            ptr_q   <= ptr_d;
            lane_q  <= lane_d;
        end
    end

    // Staging buffer; contents are don't-care after reset so it has none.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_data_q[ptr_q] <= buf_wdata;
            buf_en_q[ptr_q]   <= buf_wen;
        end
    end

endmodule
